// File: rtl/fetch_mem_arbiter.sv
// Shares one tagged memory port between icache refills and dcache misses, routing responses by tag.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module fetch_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int IC_MAX_OUT   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ic_req_valid_i,
  input  logic [ADDR_W-1:0]                ic_req_addr_i,
  output logic                             ic_req_accept_o,
  input  logic                             ic_flush_i,
  output logic                             ic_resp_valid_o,
  output logic [ADDR_W-1:0]                ic_resp_addr_o,
  output logic [DATA_W-1:0]                ic_resp_data_o,
  input  logic                             dc_req_valid_i,
  input  logic                             dc_req_store_i,
  input  logic [ADDR_W-1:0]                dc_req_addr_i,
  input  logic [DATA_W-1:0]                dc_req_data_i,
  output logic                             dc_req_accept_o,
  output logic                             dc_resp_valid_o,
  output logic [ADDR_W-1:0]                dc_resp_addr_o,
  output logic [DATA_W-1:0]                dc_resp_data_o,
  output logic [1:0]                       mem_cmd_o,
  output logic [ADDR_W-1:0]                mem_addr_o,
  output logic [DATA_W-1:0]                mem_data_o,
  input  logic [TAG_W-1:0]                 mem_tag_i,
  input  logic [TAG_W-1:0]                 mem_resp_tag_i,
  input  logic [DATA_W-1:0]                mem_resp_data_i,
  output logic [$clog2(IC_MAX_OUT+1)-1:0]  ic_outstanding_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_ic_grants_o,
  output logic [31:0]                      perf_dc_grants_o,
  output logic [31:0]                      perf_starve_overrides_o
`endif
);

  localparam int NTAGS = 1 << TAG_W;
  localparam int OUT_W = $clog2(IC_MAX_OUT + 1);
  localparam int CNT_W = $clog2(NTAGS + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10
  } cmd_t;

  logic [NTAGS-1:0]  tab_valid_reg, tab_ic_reg, tab_drop_reg;
  logic [NTAGS-1:0]  tab_valid_next, tab_ic_next, tab_drop_next;
  logic [ADDR_W-1:0] tab_addr_reg [NTAGS];
  logic [SC_W-1:0]   starve_reg, starve_next;
  logic [OUT_W-1:0]  ic_out_reg, ic_out_next;

  logic ic_elig, starve_win, ic_grant, dc_grant, tag_ok;
  logic alloc, alloc_ic, resp_hit;

  assign ic_outstanding_o = ic_out_reg;

  always_comb begin
    ic_elig    = ic_req_valid_i && !ic_flush_i && (ic_out_reg < OUT_W'(IC_MAX_OUT));
    starve_win = ic_elig && (starve_reg == SC_W'(STARVE_LIMIT));
    ic_grant   = ic_elig && (starve_win || !dc_req_valid_i);
    dc_grant   = dc_req_valid_i && !ic_grant;
    tag_ok     = (mem_tag_i != '0);
    ic_req_accept_o = ic_grant && tag_ok;
    dc_req_accept_o = dc_grant && tag_ok;

    mem_cmd_o  = CMD_NONE;
    mem_addr_o = '0;
    mem_data_o = '0;
    if (ic_grant) begin
      mem_cmd_o  = CMD_LOAD;
      mem_addr_o = ic_req_addr_i;
    end else if (dc_grant) begin
      mem_cmd_o  = dc_req_store_i ? CMD_STORE : CMD_LOAD;
      mem_addr_o = dc_req_addr_i;
      mem_data_o = dc_req_data_i;
    end

    // Stores need a tag to be accepted but never expect a response.
    alloc    = ic_req_accept_o || (dc_req_accept_o && !dc_req_store_i);
    alloc_ic = ic_req_accept_o;

    starve_next = starve_reg;
    if (ic_req_accept_o || !ic_req_valid_i || ic_flush_i)
      starve_next = '0;
    else if (ic_elig && starve_reg != SC_W'(STARVE_LIMIT))
      starve_next = starve_reg + 1'b1;
  end

  // A response in a flush cycle is already stale for the icache.
  always_comb begin
    resp_hit        = (mem_resp_tag_i != '0) && tab_valid_reg[mem_resp_tag_i];
    ic_resp_valid_o = resp_hit && tab_ic_reg[mem_resp_tag_i]
                      && !tab_drop_reg[mem_resp_tag_i] && !ic_flush_i;
    dc_resp_valid_o = resp_hit && !tab_ic_reg[mem_resp_tag_i];
    ic_resp_addr_o  = tab_addr_reg[mem_resp_tag_i];
    dc_resp_addr_o  = tab_addr_reg[mem_resp_tag_i];
    ic_resp_data_o  = mem_resp_data_i;
    dc_resp_data_o  = mem_resp_data_i;
  end

  // Allocation takes precedence over a same-cycle free of the same tag.
  generate
    for (genvar gi = 0; gi < NTAGS; gi++) begin : g_entry
      logic alloc_hit, free_hit;
      assign alloc_hit = alloc && (mem_tag_i == TAG_W'(gi));
      assign free_hit  = resp_hit && (mem_resp_tag_i == TAG_W'(gi));
      assign tab_valid_next[gi] = alloc_hit || (tab_valid_reg[gi] && !free_hit);
      assign tab_ic_next[gi]    = alloc_hit ? alloc_ic : tab_ic_reg[gi];
      assign tab_drop_next[gi]  = !alloc_hit && (tab_drop_reg[gi]
                                  || (ic_flush_i && tab_valid_reg[gi] && tab_ic_reg[gi]));
    end
  endgenerate

  always_comb begin
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NTAGS; i++)
      cnt = cnt + CNT_W'(tab_valid_next[i] && tab_ic_next[i]);
    ic_out_next = cnt[OUT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tab_valid_reg <= '0;
      tab_ic_reg    <= '0;
      tab_drop_reg  <= '0;
      starve_reg    <= '0;
      ic_out_reg    <= '0;
    end else begin
      tab_valid_reg <= tab_valid_next;
      tab_ic_reg    <= tab_ic_next;
      tab_drop_reg  <= tab_drop_next;
      starve_reg    <= starve_next;
      ic_out_reg    <= ic_out_next;
    end
  end

  always_ff @(posedge clock) begin
    if (alloc)
      tab_addr_reg[mem_tag_i] <= mem_addr_o;
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_ic_grants_o        <= '0;
      perf_dc_grants_o        <= '0;
      perf_starve_overrides_o <= '0;
    end else begin
      if (ic_req_accept_o) perf_ic_grants_o <= perf_ic_grants_o + 32'd1;
      if (dc_req_accept_o) perf_dc_grants_o <= perf_dc_grants_o + 32'd1;
      if (starve_win && dc_req_valid_i)
        perf_starve_overrides_o <= perf_starve_overrides_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: arbitration, starvation, flush, table-full, stores, tag reuse, reset.
module tb_fetch_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              ic_req_valid_i, ic_flush_i, dc_req_valid_i, dc_req_store_i;
  logic [ADDR_W-1:0] ic_req_addr_i, dc_req_addr_i;
  logic [DATA_W-1:0] dc_req_data_i, mem_resp_data_i;
  logic [TAG_W-1:0]  mem_tag_i, mem_resp_tag_i;
  logic              ic_req_accept_o, dc_req_accept_o, ic_resp_valid_o, dc_resp_valid_o;
  logic [ADDR_W-1:0] ic_resp_addr_o, dc_resp_addr_o, mem_addr_o;
  logic [DATA_W-1:0] ic_resp_data_o, dc_resp_data_o, mem_data_o;
  logic [1:0]        mem_cmd_o;
  logic [2:0]        ic_outstanding_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_ic, perf_dc, perf_so;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  fetch_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
    .ic_req_accept_o(ic_req_accept_o), .ic_flush_i(ic_flush_i),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_addr_o(ic_resp_addr_o),
    .ic_resp_data_o(ic_resp_data_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_store_i(dc_req_store_i),
    .dc_req_addr_i(dc_req_addr_i), .dc_req_data_i(dc_req_data_i),
    .dc_req_accept_o(dc_req_accept_o), .dc_resp_valid_o(dc_resp_valid_o),
    .dc_resp_addr_o(dc_resp_addr_o), .dc_resp_data_o(dc_resp_data_o),
    .mem_cmd_o(mem_cmd_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_tag_i(mem_tag_i), .mem_resp_tag_i(mem_resp_tag_i),
    .mem_resp_data_i(mem_resp_data_i), .ic_outstanding_o(ic_outstanding_o)
`ifdef MEM_ARB_PERF_EN
    , .perf_ic_grants_o(perf_ic), .perf_dc_grants_o(perf_dc),
    .perf_starve_overrides_o(perf_so)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    $display("check %s observed=%h expected=%h", tag, obs, exp);
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    ic_req_valid_i = 0; ic_req_addr_i = '0; ic_flush_i = 0;
    dc_req_valid_i = 0; dc_req_store_i = 0; dc_req_addr_i = '0; dc_req_data_i = '0;
    mem_tag_i = '0; mem_resp_tag_i = '0; mem_resp_data_i = '0;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    chk("rst_outstanding", 64'(ic_outstanding_o), 64'd0);
    chk("rst_cmd", 64'(mem_cmd_o), 64'd0);
    chk("rst_accepts", 64'({ic_req_accept_o, dc_req_accept_o}), 64'd0);
    chk("rst_resp_valid", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'd0);
    reset = 0;
    tick();

    // dcache wins a tie by default
    ic_req_valid_i = 1; ic_req_addr_i = 32'h1000;
    dc_req_valid_i = 1; dc_req_addr_i = 32'h2000; mem_tag_i = 4'd3;
    settle();
    chk("tie_dc_accept", 64'(dc_req_accept_o), 64'd1);
    chk("tie_ic_accept", 64'(ic_req_accept_o), 64'd0);
    chk("tie_cmd", 64'(mem_cmd_o), 64'd1);
    chk("tie_addr", 64'(mem_addr_o), 64'h2000);
    tick(); idle();
    mem_resp_tag_i = 4'd3; mem_resp_data_i = 64'hAAAA_5555_0000_1111;
    settle();
    chk("dc_resp_valid", 64'(dc_resp_valid_o), 64'd1);
    chk("dc_resp_addr", 64'(dc_resp_addr_o), 64'h2000);
    chk("dc_resp_data", dc_resp_data_o, 64'hAAAA_5555_0000_1111);
    chk("dc_resp_not_ic", 64'(ic_resp_valid_o), 64'd0);
    tick();
    settle();
    chk("dc_resp_freed", 64'(dc_resp_valid_o), 64'd0);
    tick(); idle();

    // starvation: dcache stores every cycle, icache wins on the 9th
    ic_req_valid_i = 1; ic_req_addr_i = 32'h3000;
    dc_req_valid_i = 1; dc_req_store_i = 1; dc_req_addr_i = 32'h4000; mem_tag_i = 4'd8;
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk($sformatf("starve_c%0d_dc", c), 64'({ic_req_accept_o, dc_req_accept_o}), 64'b01);
      tick();
    end
    settle();
    chk("starve_c9_ic", 64'({ic_req_accept_o, dc_req_accept_o}), 64'b10);
    chk("starve_c9_cmd", 64'(mem_cmd_o), 64'd1);
    chk("starve_c9_addr", 64'(mem_addr_o), 64'h3000);
    tick();
    settle();
    chk("starve_cleared", 64'({ic_req_accept_o, dc_req_accept_o}), 64'b01);
    chk("starve_out1", 64'(ic_outstanding_o), 64'd1);
    tick(); idle();
    mem_resp_tag_i = 4'd8; mem_resp_data_i = 64'h88;
    settle();
    chk("ic_resp_valid", 64'(ic_resp_valid_o), 64'd1);
    chk("ic_resp_addr", 64'(ic_resp_addr_o), 64'h3000);
    chk("ic_resp_data", ic_resp_data_o, 64'h88);
    tick(); idle();
    chk("starve_out0", 64'(ic_outstanding_o), 64'd0);

    // flush drops an outstanding refill
    ic_req_valid_i = 1; ic_req_addr_i = 32'h5000; mem_tag_i = 4'd5;
    settle();
    chk("flush_ic_accept", 64'(ic_req_accept_o), 64'd1);
    tick();
    chk("flush_out1", 64'(ic_outstanding_o), 64'd1);
    ic_flush_i = 1;
    settle();
    chk("flush_no_grant", 64'({ic_req_accept_o, mem_cmd_o}), 64'd0);
    tick(); idle();
    chk("flush_out_still1", 64'(ic_outstanding_o), 64'd1);
    mem_resp_tag_i = 4'd5; mem_resp_data_i = 64'h55;
    settle();
    chk("flush_resp_dropped", 64'(ic_resp_valid_o), 64'd0);
    tick(); idle();
    chk("flush_out0", 64'(ic_outstanding_o), 64'd0);

    // fill the icache table with tags 1..4
    for (int t = 1; t <= 4; t++) begin
      ic_req_valid_i = 1; ic_req_addr_i = 32'(t * 32'h100); mem_tag_i = 4'(t);
      settle();
      chk($sformatf("fill_accept_t%0d", t), 64'(ic_req_accept_o), 64'd1);
      tick();
    end
    mem_tag_i = 4'd9; ic_req_addr_i = 32'h900;
    settle();
    chk("full_out4", 64'(ic_outstanding_o), 64'd4);
    chk("full_no_accept", 64'(ic_req_accept_o), 64'd0);
    chk("full_cmd_none", 64'(mem_cmd_o), 64'd0);
    tick();
    mem_resp_tag_i = 4'd2; mem_resp_data_i = 64'h22;
    settle();
    chk("full_resp2_valid", 64'(ic_resp_valid_o), 64'd1);
    chk("full_resp2_addr", 64'(ic_resp_addr_o), 64'h200);
    chk("full_resp_cycle_cmd", 64'(mem_cmd_o), 64'd0);
    tick();
    mem_resp_tag_i = '0;
    settle();
    chk("resume_accept", 64'(ic_req_accept_o), 64'd1);
    tick(); idle();
    for (int t = 1; t <= 9; t++) begin
      if (t == 1 || t == 3 || t == 4 || t == 9) begin
        mem_resp_tag_i = 4'(t);
        settle();
        chk($sformatf("drain_addr_t%0d", t), 64'({ic_resp_valid_o, ic_resp_addr_o}),
            {31'd0, 1'b1, 32'(t * 32'h100)});
        tick();
      end
    end
    idle();
    chk("drain_out0", 64'(ic_outstanding_o), 64'd0);

    // store rejected, retried, then accepted without a table entry
    dc_req_valid_i = 1; dc_req_store_i = 1; dc_req_addr_i = 32'h7000;
    dc_req_data_i = 64'hDEAD_BEEF_0123_4567; mem_tag_i = 4'd0;
    settle();
    chk("store_rej_accept", 64'(dc_req_accept_o), 64'd0);
    chk("store_cmd", 64'(mem_cmd_o), 64'd2);
    chk("store_data", mem_data_o, 64'hDEAD_BEEF_0123_4567);
    tick();
    mem_tag_i = 4'd7;
    settle();
    chk("store_retry_accept", 64'(dc_req_accept_o), 64'd1);
    tick(); idle();
    mem_resp_tag_i = 4'd7;
    settle();
    chk("store_resp_ignored", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'd0);
    tick(); idle();

    // tag 6 freed by a dcache response and reallocated to the icache same cycle
    dc_req_valid_i = 1; dc_req_addr_i = 32'h6000; mem_tag_i = 4'd6;
    tick(); idle();
    mem_resp_tag_i = 4'd6; mem_resp_data_i = 64'h66;
    ic_req_valid_i = 1; ic_req_addr_i = 32'h6100; mem_tag_i = 4'd6;
    settle();
    chk("reuse_old_dc_resp", 64'({dc_resp_valid_o, dc_resp_addr_o}), {31'd0, 1'b1, 32'h6000});
    chk("reuse_ic_accept", 64'(ic_req_accept_o), 64'd1);
    tick(); idle();
    chk("reuse_out1", 64'(ic_outstanding_o), 64'd1);
    mem_resp_tag_i = 4'd6; mem_resp_data_i = 64'h67;
    settle();
    chk("reuse_new_owner", 64'({ic_resp_valid_o, dc_resp_valid_o}), 64'b10);
    chk("reuse_new_addr", 64'(ic_resp_addr_o), 64'h6100);
    tick(); idle();

    // asynchronous reset with entries live
    dc_req_valid_i = 1; dc_req_addr_i = 32'hA000; mem_tag_i = 4'd10;
    tick(); idle();
    ic_req_valid_i = 1; ic_req_addr_i = 32'hB000; mem_tag_i = 4'd11;
    tick(); idle();
    chk("arst_pre_out1", 64'(ic_outstanding_o), 64'd1);
    reset = 1;
    #1;
    chk("arst_out0", 64'(ic_outstanding_o), 64'd0);
    #1 reset = 0;
    tick();
    mem_resp_tag_i = 4'd10;
    settle();
    chk("arst_dc_ignored", 64'(dc_resp_valid_o), 64'd0);
    tick();
    mem_resp_tag_i = 4'd11;
    settle();
    chk("arst_ic_ignored", 64'(ic_resp_valid_o), 64'd0);
    tick(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
Arbitrates a single tagged memory port between the instruction-cache refill path (fetch side) and the data-cache miss path. It tracks every outstanding load tag and routes each memory response to its owner. Fetch redirects discard in-flight icache refills, so no stale lines reach the icache. It sits between icache/dcache miss logic and the memory interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, memory block width
TAG_W, 4, memory tag width; tag 0 means "not accepted / no response"
STARVE_LIMIT, 8, consecutive un-granted icache cycles before icache gets priority
IC_MAX_OUT, 4, max outstanding icache loads (dropped entries included)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ic_req_valid_i  in  1  icache refill request
ic_req_addr_i  in  ADDR_W  refill block address
ic_req_accept_o  out  1  icache request issued and tagged this cycle
ic_flush_i  in  1  fetch redirect; kill outstanding icache refills
ic_resp_valid_o  out  1  refill data valid
ic_resp_addr_o  out  ADDR_W  address of returned block
ic_resp_data_o  out  DATA_W  returned block
dc_req_valid_i  in  1  dcache request
dc_req_store_i  in  1  1=store, 0=load
dc_req_addr_i  in  ADDR_W  dcache address
dc_req_data_i  in  DATA_W  store data
dc_req_accept_o  out  1  dcache request accepted this cycle
dc_resp_valid_o  out  1  load data valid
dc_resp_addr_o  out  ADDR_W  address of returned block
dc_resp_data_o  out  DATA_W  returned block
mem_cmd_o  out  2  00 none, 01 load, 10 store
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  DATA_W  store data
mem_tag_i  in  TAG_W  same-cycle tag for issued command; 0 = rejected
mem_resp_tag_i  in  TAG_W  response tag; 0 = no response
mem_resp_data_i  in  DATA_W  response data
ic_outstanding_o  out  clog2(IC_MAX_OUT+1)  live icache table entries

Behaviour:
- Reset: tag table all invalid, starve counter 0, ic_outstanding_o 0, all resp_valid 0, accepts 0, mem_cmd_o 00.
- Grant (combinational): icache eligible iff ic_req_valid_i && !ic_flush_i && ic_outstanding_o < IC_MAX_OUT. Default priority dcache > icache. When starve_cnt == STARVE_LIMIT, eligible icache wins.
- mem_cmd_o/addr/data driven from the granted requester; 00 when none granted.
- Accept: *_accept_o = granted && mem_tag_i != 0, same cycle. Rejected requesters retry; no internal queuing.
- Accepted load: tag table entry [mem_tag_i] is written at the clock edge with {valid=1, owner, dropped=0, addr}. Accepted store allocates no entry.
- Starve counter: increments (saturating at STARVE_LIMIT) when icache is eligible but not accepted. Clears on icache accept, on !ic_req_valid_i, or on flush.
- Response: when mem_resp_tag_i != 0 and the entry is valid, output data and stored addr to the owner the same cycle (combinational), and free the entry at the edge. A dropped icache entry is freed silently with ic_resp_valid_o=0. A response on an invalid tag is ignored.
- Flush: all valid icache entries are marked dropped at the edge. A response for an icache tag in the flush cycle itself is suppressed. No icache grant in the flush cycle. Dcache entries are unaffected.
- Same tag freed by response and reallocated in the same cycle: allocation wins, entry valid with the new data.
- ic_outstanding_o counts valid icache-owned entries, including dropped ones. It is registered.
- Asynchronous reset mid-transaction: table cleared immediately. Later responses hit invalid entries and are ignored.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds 32-bit outputs perf_ic_grants_o, perf_dc_grants_o and perf_starve_overrides_o. These count accepted icache requests, accepted dcache requests, and cycles where starvation priority decided a grant. Counters are reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent.

Test Plan:
- Both valid, mem_tag_i=3 -> dc_req_accept_o=1, ic_req_accept_o=0, mem_cmd_o=01, mem_addr_o=dc addr; later mem_resp_tag_i=3 -> dc_resp_valid_o=1 with that addr/data.
- dcache valid continuously with STARVE_LIMIT=8 -> icache granted on the 9th cycle; starve counter clears after accept.
- Icache load on tag 5, ic_flush_i pulsed, then mem_resp_tag_i=5 -> ic_resp_valid_o=0, ic_outstanding_o returns 1->0.
- 4 icache loads outstanding (tags 1-4) -> icache not granted; mem_cmd_o=00 if dcache idle; response tag 2 -> grant resumes next cycle.
- Dcache store, mem_tag_i=0 -> dc_req_accept_o=0, retried next cycle; with mem_tag_i=7 -> accepted, no table entry; mem_resp_tag_i=7 is ignored.
- Response tag 6 freed and tag 6 reallocated in the same cycle -> old response routed, entry 6 valid with the new address; a later response goes to the new owner.
